// File: rtl/depacketizer_piton_pkg.sv
// Definitions shared by the Piton packetizer and depacketizer: the header
// field layout, the default count width, the receive FSM states, and a
// saturating counter helper.
package depacketizer_piton_pkg;

   // Header layout: flag, id, then the beat count.
   localparam int HDR_FLAG_BIT        = 0;
   localparam int HDR_ID_BIT          = 1;
   localparam int HDR_CNT_LSB         = 2;
   localparam int N_PKTS_BITS_DEFAULT = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_DROP = 2'd2
   } depkt_state_e;

   // 8-bit increment that sticks at all-ones.
   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/payload_out_buf.sv
// Single-entry valid/ready output register. A load marks the entry full.
// The entry empties when the consumer accepts it. The data is frozen while
// the entry is full.
module payload_out_buf #(
   parameter int PAYLOAD_WIDTH = 128
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load,
   input  logic [PAYLOAD_WIDTH-1:0] load_data,
   input  logic                     ready,
   output logic                     valid,
   output logic [PAYLOAD_WIDTH-1:0] data
);

   logic                     valid_reg;
   logic [PAYLOAD_WIDTH-1:0] data_reg;

   // A load has priority. The upstream only loads when the entry is empty,
   // so a load and a drain never compete for the entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
      end else if (load) begin
         valid_reg <= 1'b1;
         data_reg  <= load_data;
      end else if (valid_reg && ready) begin
         valid_reg <= 1'b0;
      end
   end

   assign valid = valid_reg;
   assign data  = data_reg;

endmodule

// File: rtl/depacketizer_piton.sv
// Piton receive-side depacketizer. It takes a header beat and checks its
// flag, id and beat count. It then gathers N_PKTS data beats into one
// payload with beat 0 in the LSBs. Headers that fail the check are counted,
// and their beats are discarded.
module depacketizer_piton
   import depacketizer_piton_pkg::*;
#(
   parameter int PAYLOAD_WIDTH = 128,
   parameter int PACKET_WIDTH  = 16,
   parameter int ID            = 0,
   parameter int N_PKTS_BITS   = N_PKTS_BITS_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     packet_req_i,
   input  logic [PACKET_WIDTH-1:0]  packet_i,
   output logic                     packet_grant_o,
   output logic                     packet_received_o,
   output logic                     payload_valid_o,
   output logic [PAYLOAD_WIDTH-1:0] payload_o,
   input  logic                     payload_ready_i,
   output logic [7:0]               drop_cnt_o,
   output logic                     busy_o
);

   localparam int                     N_PKTS    = PAYLOAD_WIDTH / PACKET_WIDTH;
   localparam logic [N_PKTS_BITS-1:0] N_PKTS_V  = N_PKTS_BITS'(N_PKTS);
   localparam logic [N_PKTS_BITS-1:0] LAST_BEAT = N_PKTS_BITS'(N_PKTS - 1);
   localparam logic                   ID_BIT    = (ID != 0);

   depkt_state_e             state_reg;
   logic [N_PKTS_BITS-1:0]   cnt_reg;
   logic [PAYLOAD_WIDTH-1:0] assembly_reg;
   logic [PAYLOAD_WIDTH-1:0] assembly_next;
   logic [7:0]               drop_cnt_reg;
   logic                     received_reg;

   logic                     hdr_flag;
   logic                     hdr_id;
   logic [N_PKTS_BITS-1:0]   hdr_cnt;
   logic                     hdr_match;
   logic                     last_beat;
   logic                     buf_valid;

   assign hdr_flag  = packet_i[HDR_FLAG_BIT];
   assign hdr_id    = packet_i[HDR_ID_BIT];
   assign hdr_cnt   = packet_i[HDR_CNT_LSB +: N_PKTS_BITS];
   assign hdr_match = (hdr_id == ID_BIT) && (hdr_cnt == N_PKTS_V);

   // A header is taken only when idle and the output entry is free, so a
   // completed payload always has an empty buffer to land in.
   assign packet_grant_o = packet_req_i && (state_reg == ST_IDLE) && !buf_valid;
   assign last_beat      = (state_reg == ST_DATA) && (cnt_reg == LAST_BEAT);

   // The assembly view includes the beat on the bus now. The final beat can
   // then go straight into the output buffer with the earlier ones.
   generate
      for (genvar gi = 0; gi < N_PKTS; gi++) begin : g_slot
         assign assembly_next[gi*PACKET_WIDTH +: PACKET_WIDTH] =
            (cnt_reg == N_PKTS_BITS'(gi)) ? packet_i
                                          : assembly_reg[gi*PACKET_WIDTH +: PACKET_WIDTH];
      end
   endgenerate

   // Receive FSM: header check, beat gathering, beat discard, drop counting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         cnt_reg      <= '0;
         assembly_reg <= '0;
         drop_cnt_reg <= '0;
         received_reg <= 1'b0;
      end else begin
         received_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (packet_grant_o) begin
                  if (!hdr_flag) begin
                     drop_cnt_reg <= sat_inc8(drop_cnt_reg);
                  end else if (hdr_match) begin
                     state_reg <= ST_DATA;
                     cnt_reg   <= '0;
                  end else begin
                     drop_cnt_reg <= sat_inc8(drop_cnt_reg);
                     if (hdr_cnt != '0) begin
                        state_reg <= ST_DROP;
                        cnt_reg   <= hdr_cnt;
                     end
                  end
               end
            end
            ST_DATA: begin
               assembly_reg <= assembly_next;
               cnt_reg      <= cnt_reg + 1'b1;
               if (last_beat) begin
                  state_reg    <= ST_IDLE;
                  cnt_reg      <= '0;
                  received_reg <= 1'b1;
               end
            end
            ST_DROP: begin
               cnt_reg <= cnt_reg - 1'b1;
               if (cnt_reg == N_PKTS_BITS'(1)) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               cnt_reg   <= '0;
            end
         endcase
      end
   end

   payload_out_buf #(
      .PAYLOAD_WIDTH (PAYLOAD_WIDTH)
   ) u_out_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (last_beat),
      .load_data (assembly_next),
      .ready     (payload_ready_i),
      .valid     (buf_valid),
      .data      (payload_o)
   );

   assign payload_valid_o   = buf_valid;
   assign packet_received_o = received_reg;
   assign drop_cnt_o        = drop_cnt_reg;
   assign busy_o            = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_depacketizer_piton.sv
// Scoreboard bench for depacketizer_piton with the default parameters.
// The stimulus pushes hand-computed payloads into a queue. A monitor pops
// and compares one entry on every accepted payload.
module tb_depacketizer_piton;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         packet_req_i = 1'b0;
   logic [15:0]  packet_i = '0;
   logic         payload_ready_i = 1'b0;
   logic         packet_grant_o;
   logic         packet_received_o;
   logic         payload_valid_o;
   logic [127:0] payload_o;
   logic [7:0]   drop_cnt_o;
   logic         busy_o;

   logic [127:0] exp_q[$];
   logic [127:0] mon_want;
   int           n_cmp = 0;
   int           n_bad = 0;
   int           exp_rcv = 0;
   int           got_rcv = 0;
   int           exp_drop = 0;

   depacketizer_piton dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .packet_req_i      (packet_req_i),
      .packet_i          (packet_i),
      .packet_grant_o    (packet_grant_o),
      .packet_received_o (packet_received_o),
      .payload_valid_o   (payload_valid_o),
      .payload_o         (payload_o),
      .payload_ready_i   (payload_ready_i),
      .drop_cnt_o        (drop_cnt_o),
      .busy_o            (busy_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   // Monitor: one scoreboard pop per accepted payload, plus received-pulse checks.
   always @(negedge clk) begin
      if (rst_n && payload_valid_o && payload_ready_i) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL payload_unexpected: got %h want none", payload_o);
         end else begin
            mon_want = exp_q.pop_front();
            if (payload_o !== mon_want) begin
               n_bad++;
               $display("FAIL payload: got %h want %h", payload_o, mon_want);
            end else begin
               $display("payload ok %h", payload_o);
            end
         end
      end
      if (rst_n && packet_received_o) begin
         got_rcv++;
         n_cmp++;
         if (payload_valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL received_without_valid: got valid %b want 1", payload_valid_o);
         end
      end
   end

   // Present a header and hold it until granted, with a bounded wait.
   // Returns one cycle after the grant cycle, which is the first data cycle.
   task automatic send_hdr(input logic [15:0] hdr);
      int n;
      n = 0;
      packet_req_i = 1'b1;
      packet_i     = hdr;
      @(negedge clk);
      while (!packet_grant_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("grant_wait", packet_grant_o, 1);
      @(posedge clk); #1;
      packet_req_i = 1'b0;
      packet_i     = '0;
   endtask

   task automatic send_beats(input logic [15:0] base, input logic [15:0] step, input int nb);
      for (int i = 0; i < nb; i++) begin
         packet_i = base + step * 16'(i);
         @(posedge clk); #1;
      end
      packet_i = '0;
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", payload_valid_o, 0);
      check("rst_payload", payload_o, 0);
      check("rst_received", packet_received_o, 0);
      check("rst_drop", drop_cnt_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_grant", packet_grant_o, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: basic packet, valid and received pulse at t+9 only
      payload_ready_i = 1'b1;
      exp_q.push_back(128'h8888_7777_6666_5555_4444_3333_2222_1111);
      exp_rcv++;
      send_hdr(16'h0021);
      send_beats(16'h1111, 16'h1111, 8);
      @(negedge clk);
      check("t1_valid", payload_valid_o, 1);
      check("t1_received", packet_received_o, 1);
      check("t1_payload", payload_o, 128'h8888_7777_6666_5555_4444_3333_2222_1111);
      @(negedge clk);
      check("t1_received_gone", packet_received_o, 0);
      check("t1_valid_gone", payload_valid_o, 0);
      @(posedge clk); #1;

      // 2: full buffer blocks the grant; a consume at u allows a grant at u+1
      payload_ready_i = 1'b0;
      exp_q.push_back(128'hA008_A007_A006_A005_A004_A003_A002_A001);
      exp_rcv++;
      send_hdr(16'h0021);
      send_beats(16'hA001, 16'h0001, 8);
      packet_req_i = 1'b1;
      packet_i     = 16'h0021;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t2_grant_blocked", packet_grant_o, 0);
      end
      @(posedge clk); #1;
      payload_ready_i = 1'b1;
      @(negedge clk);
      check("t2_grant_at_u", packet_grant_o, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("t2_grant_at_u1", packet_grant_o, 1);
      @(posedge clk); #1;
      packet_req_i = 1'b0;
      exp_q.push_back(128'h5A08_5A07_5A06_5A05_5A04_5A03_5A02_5A01);
      exp_rcv++;
      send_beats(16'h5A01, 16'h0001, 8);
      @(negedge clk);
      check("t2_second_valid", payload_valid_o, 1);
      @(posedge clk); #1;

      // 3: bad id, count 8 -> eight dropped beats, then a normal packet
      send_hdr(16'h0023);
      exp_drop++;
      for (int i = 0; i < 8; i++) begin
         packet_i = 16'hDEAD;
         @(negedge clk);
         check("t3_busy_drop", busy_o, 1);
         @(posedge clk); #1;
      end
      packet_i = '0;
      @(negedge clk);
      check("t3_idle", busy_o, 0);
      check("t3_drop_cnt", drop_cnt_o, 8'(exp_drop));
      check("t3_no_valid", payload_valid_o, 0);
      @(posedge clk); #1;
      exp_q.push_back(128'h4308_4207_4106_4005_3F04_3E03_3D02_3C01);
      exp_rcv++;
      send_hdr(16'h0021);
      send_beats(16'h3C01, 16'h0101, 8);
      @(negedge clk);
      check("t3_after_valid", payload_valid_o, 1);
      @(posedge clk); #1;

      // 4: count mismatch (4 beats), then flag=0
      send_hdr(16'h0011);
      exp_drop++;
      for (int i = 0; i < 4; i++) begin
         packet_i = 16'hBEEF;
         @(negedge clk);
         check("t4_busy_drop", busy_o, 1);
         @(posedge clk); #1;
      end
      packet_i = '0;
      @(negedge clk);
      check("t4_idle_t5", busy_o, 0);
      check("t4_drop_cnt", drop_cnt_o, 8'(exp_drop));
      @(posedge clk); #1;
      send_hdr(16'h0020);
      exp_drop++;
      @(negedge clk);
      check("t4_flag0_idle", busy_o, 0);
      check("t4_flag0_drop", drop_cnt_o, 8'(exp_drop));
      @(posedge clk); #1;

      // 5: reset in the middle of a DATA packet, then a fresh packet
      send_hdr(16'h0021);
      send_beats(16'h7701, 16'h0001, 3);
      rst_n = 1'b0;
      #1;
      exp_drop = 0;
      check("t5_rst_busy", busy_o, 0);
      check("t5_rst_valid", payload_valid_o, 0);
      check("t5_rst_payload", payload_o, 0);
      check("t5_rst_drop", drop_cnt_o, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      exp_q.push_back(128'hB008_B007_B006_B005_B004_B003_B002_B001);
      exp_rcv++;
      send_hdr(16'h0021);
      send_beats(16'hB001, 16'h0001, 8);
      @(negedge clk);
      check("t5_fresh_valid", payload_valid_o, 1);
      @(posedge clk); #1;

      // 6: back-to-back bad-id headers with count 0 saturate the drop counter
      packet_req_i = 1'b1;
      packet_i     = 16'h0003;
      repeat (100) @(posedge clk);
      #1;
      check("t6_drop_100", drop_cnt_o, 8'd100);
      repeat (200) @(posedge clk);
      #1;
      packet_req_i = 1'b0;
      packet_i     = '0;
      check("t6_drop_sat", drop_cnt_o, 8'hFF);
      check("t6_idle", busy_o, 0);

      // Drain and account
      repeat (5) @(negedge clk);
      check("sb_empty", 128'(exp_q.size()), 0);
      check("received_count", 128'(got_rcv), 128'(exp_rcv));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
